// File: rtl/bcd_7seg_display_scanner.sv
// Multiplexed N-digit 7-segment scanner.
// Takes a snapshot of the packed BCD bus and decimal-point mask once per scan
// frame, so a digit never tears mid-frame. It drives one digit per time slot.
// At the start of each slot a short guard window keeps all anodes off, which
// prevents ghosting. Leading zeros are blanked. Every output is registered.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en          scan enable; low keeps the display dark and freezes the scan state
//   BCD         packed digits, digit k = BCD[4k+3:4k], digit 0 is the LSD
//   dp_mask     decimal point per digit (1 = lit), captured with the BCD snapshot
//   seg         {g,f,e,d,c,b,a}; polarity set by ACT_LOW
//   dp          decimal point; polarity set by ACT_LOW
//   anode       one-hot digit select; polarity set by ACT_LOW
//   frame_start one-cycle pulse as the digit 0 slot begins on a fresh snapshot
module bcd_7seg_display_scanner #(
  parameter int unsigned N        = 3,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned GUARD    = 16,
  parameter bit          ACT_LOW  = 1'b1,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [4*N-1:0] BCD,
  input  logic [N-1:0]   dp_mask,
  output logic [6:0]     seg,
  output logic           dp,
  output logic [N-1:0]   anode,
  output logic           frame_start
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [SelW-1:0] SelMax = SelW'(N - 1);

  // Active-high segment pattern for one BCD code. Codes A-F show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Scan state
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [4*N-1:0]  shadow_bcd_q, shadow_bcd_d;
  logic [N-1:0]    shadow_dp_q, shadow_dp_d;
  logic            load_pending_q, load_pending_d;
  logic            tick, load;

  // Registered outputs
  logic [6:0]   seg_q, seg_d;
  logic         dp_q, dp_d;
  logic [N-1:0] anode_q, anode_d;
  logic         frame_start_q;

  // Next-state for the divider, the slot select and the snapshot
  always_comb begin
    div_cnt_d      = div_cnt_q;
    sel_d          = sel_q;
    shadow_bcd_d   = shadow_bcd_q;
    shadow_dp_d    = shadow_dp_q;
    load_pending_d = load_pending_q;

    tick = en && (div_cnt_q == DivMax);
    // Snapshot as the last slot of a frame ends, or on the first enabled cycle after reset.
    load = en && (load_pending_q || (tick && (sel_q == SelMax)));

    if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end
    if (tick) begin
      sel_d = (sel_q == SelMax) ? '0 : sel_q + 1'b1;
    end
    if (load) begin
      shadow_bcd_d   = BCD;
      shadow_dp_d    = dp_mask;
      load_pending_d = 1'b0;
    end
  end

  // lz[k] is set when shadow digits N-1..k are all zero. lz[0] stays 0, so digit 0
  // is never blanked.
  logic [N-1:0] lz;
  logic         zero_run;
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int k = int'(N) - 1; k >= 1; k--) begin
      zero_run = zero_run && (shadow_bcd_q[4*k +: 4] == 4'd0);
      lz[k]    = zero_run;
    end
  end

  // Output decode for the current slot, worked out in the active-high view
  logic [3:0]   digit;
  logic         digit_dp, digit_blank;
  logic [6:0]   seg_hi;
  logic         dp_hi;
  logic [N-1:0] anode_hi;
  always_comb begin
    digit       = '0;
    digit_dp    = 1'b0;
    digit_blank = 1'b0;
    anode_hi    = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (sel_q == SelW'(k)) begin
        digit       = shadow_bcd_q[4*k +: 4];
        digit_dp    = shadow_dp_q[k];
        digit_blank = BLANK_LZ && lz[k];
        // Anodes stay dark during the guard window; seg/dp settle meanwhile.
        if (32'(div_cnt_q) >= GUARD) begin
          anode_hi[k] = 1'b1;
        end
      end
    end

    seg_hi = digit_blank ? 7'h00 : decode(digit);
    dp_hi  = digit_dp;
    if (!en) begin
      seg_hi   = '0;
      dp_hi    = 1'b0;
      anode_hi = '0;
    end

    seg_d   = ACT_LOW ? ~seg_hi : seg_hi;
    dp_d    = ACT_LOW ? ~dp_hi : dp_hi;
    anode_d = ACT_LOW ? ~anode_hi : anode_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q      <= '0;
      sel_q          <= '0;
      shadow_bcd_q   <= '0;
      shadow_dp_q    <= '0;
      load_pending_q <= 1'b1;
      seg_q          <= {7{ACT_LOW}};
      dp_q           <= ACT_LOW;
      anode_q        <= {N{ACT_LOW}};
      frame_start_q  <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      sel_q          <= sel_d;
      shadow_bcd_q   <= shadow_bcd_d;
      shadow_dp_q    <= shadow_dp_d;
      load_pending_q <= load_pending_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      anode_q        <= anode_d;
      frame_start_q  <= load;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign anode       = anode_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_7seg_display_scanner.sv
// Directed bench for bcd_7seg_display_scanner with N=3, SCAN_DIV=4, GUARD=1,
// active-low pins and leading-zero blanking. Inputs change on the falling edge
// and outputs are sampled there too.
module tb_bcd_7seg_display_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] bcd;
  logic [2:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  anode;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_7seg_display_scanner #(
    .N        (3),
    .SCAN_DIV (4),
    .GUARD    (1),
    .ACT_LOW  (1'b1),
    .BLANK_LZ (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .BCD         (bcd),
    .dp_mask     (dp_mask),
    .seg         (seg),
    .dp          (dp),
    .anode       (anode),
    .frame_start (frame_start)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // Expected anode pattern for step i of a frame started right after reset.
  // The first cycle of each 4-cycle slot is the guard cycle.
  function automatic logic [2:0] slot_anode(input int i);
    case (i % 12)
      0, 4, 8:  return 3'b111;
      1, 2, 3:  return 3'b110;
      5, 6, 7:  return 3'b101;
      default:  return 3'b011;
    endcase
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b0;
    step();
    step();
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    en      = 1'b0;
    bcd     = 12'h000;
    dp_mask = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (seg !== 7'h7F) begin
        failures++;
        $display("FAIL reset_seg cyc=%0d got=%h exp=7f", i, seg);
      end
      checks++;
      if (dp !== 1'b1) begin
        failures++;
        $display("FAIL reset_dp cyc=%0d got=%b exp=1", i, dp);
      end
      checks++;
      if (anode !== 3'b111) begin
        failures++;
        $display("FAIL reset_anode cyc=%0d got=%b exp=111", i, anode);
      end
      checks++;
      if (frame_start !== 1'b0) begin
        failures++;
        $display("FAIL reset_fs cyc=%0d got=%b exp=0", i, frame_start);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg;
    logic       exp_fs;
    do_reset();
    bcd     = 12'h123;
    dp_mask = 3'b000;
    en      = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      // Step 0 still shows the empty pre-snapshot shadow: digit 0 = '0'.
      if (i == 0) exp_seg = 7'h40;
      else begin
        case ((i % 12) / 4)
          0:       exp_seg = 7'h30;
          1:       exp_seg = 7'h24;
          default: exp_seg = 7'h79;
        endcase
      end
      exp_fs = (i == 0) || (i % 12 == 11);
      checks++;
      if (anode !== slot_anode(i)) begin
        failures++;
        $display("FAIL scan_anode cyc=%0d got=%b exp=%b", i, anode, slot_anode(i));
      end
      checks++;
      if (seg !== exp_seg) begin
        failures++;
        $display("FAIL scan_seg cyc=%0d got=%h exp=%h", i, seg, exp_seg);
      end
      checks++;
      if (frame_start !== exp_fs) begin
        failures++;
        $display("FAIL scan_fs cyc=%0d got=%b exp=%b", i, frame_start, exp_fs);
      end
      checks++;
      if (dp !== 1'b1) begin
        failures++;
        $display("FAIL scan_dp cyc=%0d got=%b exp=1", i, dp);
      end
    end
  endtask

  task automatic test_tearing();
    logic [6:0] exp_seg;
    logic       exp_fs;
    do_reset();
    bcd     = 12'h123;
    dp_mask = 3'b000;
    en      = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (i == 0) exp_seg = 7'h40;
      else if (i < 12) begin
        case ((i % 12) / 4)
          0:       exp_seg = 7'h30;
          1:       exp_seg = 7'h24;
          default: exp_seg = 7'h79;
        endcase
      end else begin
        case ((i % 12) / 4)
          0:       exp_seg = 7'h02;
          1:       exp_seg = 7'h12;
          default: exp_seg = 7'h19;
        endcase
      end
      exp_fs = (i == 0) || (i % 12 == 11);
      if (i >= 6) begin
        checks++;
        if (seg !== exp_seg) begin
          failures++;
          $display("FAIL tear_seg cyc=%0d got=%h exp=%h", i, seg, exp_seg);
        end
        checks++;
        if (anode !== slot_anode(i)) begin
          failures++;
          $display("FAIL tear_anode cyc=%0d got=%b exp=%b", i, anode, slot_anode(i));
        end
        checks++;
        if (frame_start !== exp_fs) begin
          failures++;
          $display("FAIL tear_fs cyc=%0d got=%b exp=%b", i, frame_start, exp_fs);
        end
      end
      // Change the input in the middle of the digit 1 slot.
      if (i == 5) bcd = 12'h456;
    end
  endtask

  task automatic test_blanking();
    logic [11:0] vec_bcd [2];
    logic [6:0]  vec_seg [2][3];
    logic [6:0]  exp_seg;
    vec_bcd[0] = 12'h007;
    vec_seg[0] = '{7'h78, 7'h7F, 7'h7F};
    vec_bcd[1] = 12'h000;
    vec_seg[1] = '{7'h40, 7'h7F, 7'h7F};
    for (int v = 0; v < 2; v++) begin
      do_reset();
      bcd     = vec_bcd[v];
      dp_mask = 3'b000;
      en      = 1'b1;
      for (int i = 0; i < 12; i++) begin
        step();
        exp_seg = (i == 0) ? 7'h40 : vec_seg[v][i / 4];
        checks++;
        if (seg !== exp_seg) begin
          failures++;
          $display("FAIL blank_seg bcd=%h cyc=%0d got=%h exp=%h", vec_bcd[v], i, seg, exp_seg);
        end
        checks++;
        if (anode !== slot_anode(i)) begin
          failures++;
          $display("FAIL blank_anode bcd=%h cyc=%0d got=%b exp=%b", vec_bcd[v], i, anode,
                   slot_anode(i));
        end
      end
    end
  endtask

  task automatic test_invalid_dp();
    logic [6:0] exp_seg;
    logic       exp_dp;
    do_reset();
    bcd     = 12'h1A0;
    dp_mask = 3'b010;
    en      = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      case (i / 4)
        0:       begin exp_seg = 7'h40; exp_dp = 1'b1; end
        1:       begin exp_seg = 7'h3F; exp_dp = 1'b0; end
        default: begin exp_seg = 7'h79; exp_dp = 1'b1; end
      endcase
      checks++;
      if (seg !== exp_seg) begin
        failures++;
        $display("FAIL inv_seg cyc=%0d got=%h exp=%h", i, seg, exp_seg);
      end
      checks++;
      if (dp !== exp_dp) begin
        failures++;
        $display("FAIL inv_dp cyc=%0d got=%b exp=%b", i, dp, exp_dp);
      end
    end
  endtask

  task automatic test_en_toggle();
    logic [2:0] res_an  [4];
    logic [6:0] res_seg [4];
    res_an  = '{3'b101, 3'b101, 3'b111, 3'b011};
    res_seg = '{7'h24, 7'h24, 7'h79, 7'h79};
    do_reset();
    bcd     = 12'h123;
    dp_mask = 3'b000;
    en      = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (anode !== 3'b101) begin
      failures++;
      $display("FAIL en_pre_anode got=%b exp=101", anode);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (anode !== 3'b111 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
        failures++;
        $display("FAIL en_gap cyc=%0d got an=%b seg=%h dp=%b fs=%b exp an=111 seg=7f dp=1 fs=0",
                 i, anode, seg, dp, frame_start);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (anode !== res_an[i]) begin
        failures++;
        $display("FAIL en_resume_anode cyc=%0d got=%b exp=%b", i, anode, res_an[i]);
      end
      checks++;
      if (seg !== res_seg[i]) begin
        failures++;
        $display("FAIL en_resume_seg cyc=%0d got=%h exp=%h", i, seg, res_seg[i]);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    bcd     = 12'h000;
    dp_mask = 3'b000;
    test_reset();
    test_scan();
    test_tearing();
    test_blanking();
    test_invalid_dp();
    test_en_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
